// File: rtl/q_pkg.sv
// Shared definitions for the clocked q_* handshake blocks: FSM state encoding and a clog2 helper.
package q_pkg;

    typedef enum logic [1:0] {
        Q_IDLE    = 2'd0,
        Q_REQ     = 2'd1,
        Q_RELEASE = 2'd2
    } q_state_t;

    function automatic int unsigned q_clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/q_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input (e.g. a four-phase ack).
module q_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/q_hs_source.sv
// Clocked token source: buffers valid/ready words and issues each as a four-phase
// request with bundled data held stable until the synchronised ack is seen.
module q_hs_source
    import q_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [DATA_W-1:0]        push_data,
    output logic                     r_out,
    input  logic                     a_out,
    output logic [DATA_W-1:0]        data_out,
    output logic [q_clog2(DEPTH):0]  level,
    output logic [CNT_W-1:0]         sent_count,
    output logic                     proto_err
);

    localparam int unsigned AW    = q_clog2(DEPTH);
    localparam int unsigned LVL_W = AW + 1;

    q_state_t          state, state_nxt;
    logic              ack_s, ack_d;
    logic              rdy_q;
    logic              push, pop, load, done;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    q_sync #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (a_out),
        .q   (ack_s)
    );

    // rdy_q keeps push_ready low while reset is held and until the first edge after release.
    assign push_ready = rdy_q && (level < LVL_W'(DEPTH));
    assign push       = push_valid && push_ready;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        done      = 1'b0;
        unique case (state)
            Q_IDLE: begin
                if ((level != '0) && !ack_s) begin
                    state_nxt = Q_REQ;
                    load      = 1'b1;
                end
            end
            Q_REQ: begin
                if (ack_s) begin
                    state_nxt = Q_RELEASE;
                    pop       = 1'b1;
                end
            end
            Q_RELEASE: begin
                if (!ack_s) begin
                    state_nxt = Q_IDLE;
                    done      = 1'b1;
                end
            end
            default: state_nxt = Q_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= Q_IDLE;
            r_out      <= 1'b0;
            data_out   <= '0;
            ack_d      <= 1'b0;
            rdy_q      <= 1'b0;
            proto_err  <= 1'b0;
            sent_count <= '0;
        end else begin
            state <= state_nxt;
            r_out <= (state_nxt == Q_REQ);
            ack_d <= ack_s;
            rdy_q <= 1'b1;
            if (load) begin
                data_out <= mem[rd_ptr];
            end
            if (done) begin
                sent_count <= sent_count + CNT_W'(1);
            end
            if ((state == Q_IDLE) && ack_s && !ack_d) begin
                proto_err <= 1'b1;
            end
        end
    end

    // Storage carries no reset; occupancy and pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_q_hs_source.sv
// Directed bench for q_hs_source with a behavioural four-phase acknowledging stage.
module tb_q_hs_source;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned DEPTH       = 4;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned CNT_W       = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              push_valid = 1'b0;
    logic              push_ready;
    logic [DATA_W-1:0] push_data = '0;
    logic              r_out;
    logic              a_out = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic [2:0]        level;
    logic [CNT_W-1:0]  sent_count;
    logic              proto_err;

    int unsigned n_chk    = 0;
    int unsigned n_pass   = 0;
    int unsigned exp_sent = 0;

    always #5 clk = ~clk;

    q_hs_source #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_data  (push_data),
        .r_out      (r_out),
        .a_out      (a_out),
        .data_out   (data_out),
        .level      (level),
        .sent_count (sent_count),
        .proto_err  (proto_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        int unsigned w;
        w = 0;
        push_valid = 1'b1;
        push_data  = d;
        @(negedge clk);
        while (!push_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("push_ready", 32'(push_ready), 32'd1);
        @(posedge clk);
        #1;
        push_valid = 1'b0;
    endtask

    task automatic wait_sent();
        int unsigned w;
        w = 0;
        while (sent_count !== CNT_W'(exp_sent) && w < 50) begin
            tick(1);
            w++;
        end
        check("sent_count", 32'(sent_count), exp_sent);
    endtask

    // Acknowledging stage: waits for the request, acks after dly cycles, releases once r_out falls.
    task automatic deliver(input logic [DATA_W-1:0] d, input int unsigned dly);
        int unsigned w;
        logic        bad;
        w   = 0;
        bad = 1'b0;
        while (!r_out && w < 300) begin
            tick(1);
            w++;
        end
        check("req_rise", 32'(r_out), 32'd1);
        check("data_out", 32'(data_out), 32'(d));
        repeat (dly) begin
            tick(1);
            if (!r_out || data_out !== d) bad = 1'b1;
        end
        a_out = 1'b1;
        w = 0;
        while (r_out && w < 50) begin
            if (data_out !== d) bad = 1'b1;
            tick(1);
            w++;
        end
        check("req_fall", 32'(r_out), 32'd0);
        check("data_stable", 32'(bad), 32'd0);
        a_out = 1'b0;
        exp_sent++;
        wait_sent();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // reset values while rst is held low
        #2;
        check("rst_r_out", 32'(r_out), 32'd0);
        check("rst_push_ready", 32'(push_ready), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_sent", 32'(sent_count), 32'd0);
        check("rst_proto_err", 32'(proto_err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("ready_pre_edge", 32'(push_ready), 32'd0);
        @(posedge clk);
        #1;
        check("ready_post_edge", 32'(push_ready), 32'd1);

        // single word with 1-cycle issue latency
        push(8'hA5);
        check("single_level", 32'(level), 32'd1);
        check("single_r_early", 32'(r_out), 32'd0);
        tick(1);
        check("single_latency", 32'(r_out), 32'd1);
        deliver(8'hA5, 3);
        check("single_level_end", 32'(level), 32'd0);

        // fill with ack held low; fifth word refused
        for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
        check("fill_level", 32'(level), 32'd4);
        check("fill_ready", 32'(push_ready), 32'd0);
        push_valid = 1'b1;
        push_data  = 8'hEE;
        tick(3);
        check("fill_level_hold", 32'(level), 32'd4);
        push_valid = 1'b0;
        for (int i = 0; i < 4; i++) deliver(8'(8'h10 + i), 1);
        check("fill_drained", 32'(level), 32'd0);

        // stream with random ack delays, producer and stage running concurrently
        fork
            begin
                for (int i = 0; i < 8; i++) push(8'(8'h30 + i));
            end
            begin
                for (int j = 0; j < 8; j++) deliver(8'(8'h30 + j), $urandom_range(10, 0));
            end
        join
        check("stream_level", 32'(level), 32'd0);

        // push coincides with the pop edge at level 2
        push(8'h50);
        push(8'h51);
        check("simul_level_pre", 32'(level), 32'd2);
        check("simul_req", 32'(r_out), 32'd1);
        check("simul_data", 32'(data_out), 32'h50);
        a_out = 1'b1;
        tick(2);
        check("simul_req_hold", 32'(r_out), 32'd1);
        push_valid = 1'b1;
        push_data  = 8'h52;
        tick(1);
        push_valid = 1'b0;
        check("simul_level", 32'(level), 32'd2);
        check("simul_released", 32'(r_out), 32'd0);
        a_out = 1'b0;
        exp_sent++;
        wait_sent();
        deliver(8'h51, 2);
        deliver(8'h52, 0);
        check("simul_level_end", 32'(level), 32'd0);

        // spurious ack while idle
        a_out = 1'b1;
        tick(3);
        a_out = 1'b0;
        tick(4);
        check("glitch_err", 32'(proto_err), 32'd1);
        check("glitch_no_req", 32'(r_out), 32'd0);
        check("glitch_sent", 32'(sent_count), exp_sent);
        tick(5);
        check("glitch_sticky", 32'(proto_err), 32'd1);
        push(8'h77);
        deliver(8'h77, 2);
        check("glitch_sticky_end", 32'(proto_err), 32'd1);

        // reset in the middle of a request with ack high
        push(8'h99);
        push(8'h9A);
        check("mid_req", 32'(r_out), 32'd1);
        a_out = 1'b1;
        tick(1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_r_out", 32'(r_out), 32'd0);
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_data", 32'(data_out), 32'd0);
        check("mid_rst_sent", 32'(sent_count), 32'd0);
        check("mid_rst_err", 32'(proto_err), 32'd0);
        check("mid_rst_ready", 32'(push_ready), 32'd0);
        exp_sent = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_ready_back", 32'(push_ready), 32'd1);
        push(8'h3C);
        tick(6);
        check("stale_ack_no_req", 32'(r_out), 32'd0);
        check("stale_ack_level", 32'(level), 32'd1);
        a_out = 1'b0;
        deliver(8'h3C, 0);
        check("final_level", 32'(level), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
